// File: rtl/rmii_rx_framer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_pkg : shared RMII framer states, dibit codes and CRC-32 helpers   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package eth_pkg;

  typedef enum logic [1:0] {
    DROP     = 2'd0,
    IDLE     = 2'd1,
    PREAMBLE = 2'd2,
    DATA     = 2'd3
  } rx_state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;

  // One step of the reflected CRC-32 register for a single wire bit.
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
    crc32_bit = (crc >> 1) ^ ((crc[0] ^ b) ? CRC_POLY : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rmii_rx_framer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rmii_rx_framer_if : RMII receive pins and framed dibit output bundle  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rmii_rx_framer_if;
  logic        crsdv;
  logic [1:0]  rxd;
  logic        axiov;
  logic [1:0]  axiod;
  logic        frame_done;
  logic        frame_ok;
  logic [10:0] frame_len;

  modport master (output crsdv, rxd, input axiov, axiod, frame_done, frame_ok, frame_len);
  modport slave  (input crsdv, rxd, output axiov, axiod, frame_done, frame_ok, frame_len);
endinterface
`default_nettype wire

// File: rtl/crc32_dibit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc32_dibit : registered reflected CRC-32, two wire bits per cycle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module crc32_dibit
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [1:0]  i_dibit,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // Bit 0 of the dibit is earlier on the wire, so it is folded in first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= CRC_INIT;
    end else if (i_clear) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= crc32_bit(crc32_bit(r_crc, i_dibit[0]), i_dibit[1]);
    end
  end

  assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/rmii_rx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rmii_rx_framer : RMII preamble/SFD hunt, FCS strip and frame verdict  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rmii_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_PREAMBLE = 8,
  parameter int MIN_BYTES    = 64,
  parameter int MAX_BYTES    = 1522
) (
  input  logic             clk,
  input  logic             rst,
  rmii_rx_framer_if.slave  rx
);

  localparam logic [4:0]  c_min_pre   = 5'(MIN_PREAMBLE);
  localparam logic [11:0] c_min_bytes = 12'(MIN_BYTES);
  localparam logic [11:0] c_max_bytes = 12'(MAX_BYTES);

  logic             r_crsdv, r_crsdv_d;
  logic [1:0]       r_rxd;
  rx_state_t        r_state, w_next;
  logic [4:0]       r_pre_cnt;
  logic [13:0]      r_cnt;
  logic [15:0][1:0] r_line;
  logic             r_pop_v;
  logic [1:0]       r_pop_d;
  logic             r_axiov;
  logic [1:0]       r_axiod;
  logic             r_done, r_ok;
  logic [10:0]      r_len;
  logic             w_eoc, w_shift, w_clear, w_done, w_ok;
  logic [31:0]      w_crc;
  logic [11:0]      w_bytes, w_len_full;
  logic [10:0]      w_len;

  // Carrier is assumed present out of reset, so two genuine idle samples
  // are needed before the hunt starts and a mid-frame release cannot alias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crsdv   <= 1'b1;
      r_crsdv_d <= 1'b1;
      r_rxd     <= 2'b00;
    end else begin
      r_crsdv   <= rx.crsdv;
      r_crsdv_d <= r_crsdv;
      r_rxd     <= rx.rxd;
    end
  end

  assign w_eoc = ~r_crsdv & ~r_crsdv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DROP;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_clear = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      DROP: begin
        if (w_eoc) w_next = IDLE;
      end
      IDLE: begin
        if (r_crsdv) w_next = (r_rxd == PREAMBLE_DIBIT) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (w_eoc) begin
          w_next = IDLE;
        end else if (r_crsdv) begin
          if (r_rxd == SFD_DIBIT) begin
            w_next  = (r_pre_cnt >= c_min_pre) ? DATA : DROP;
            w_clear = (r_pre_cnt >= c_min_pre);
          end else if (r_rxd != PREAMBLE_DIBIT) begin
            w_next = DROP;
          end
        end
      end
      DATA: begin
        w_shift = r_crsdv;
        if (w_eoc) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = DROP;
    endcase
  end

  // Dibit counter spans 4095 bytes so the MAX_BYTES limit and the
  // 2047-byte length ceiling remain reachable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= 5'd0;
      r_cnt     <= 14'd0;
      r_line    <= '0;
    end else begin
      if (r_state == IDLE && w_next == PREAMBLE) begin
        r_pre_cnt <= 5'd1;
      end else if (r_state == PREAMBLE && r_crsdv && r_rxd == PREAMBLE_DIBIT
                   && r_pre_cnt != 5'd31) begin
        r_pre_cnt <= r_pre_cnt + 5'd1;
      end
      if (w_clear) begin
        r_cnt <= 14'd0;
      end else if (w_shift && r_cnt != 14'h3FFF) begin
        r_cnt <= r_cnt + 14'd1;
      end
      if (w_shift) r_line <= {r_line[14:0], r_rxd};
    end
  end

  crc32_dibit u_crc (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (w_shift),
    .i_dibit (r_rxd),
    .o_crc   (w_crc)
  );

  assign w_bytes    = r_cnt[13:2];
  assign w_len_full = (w_bytes < 12'd4) ? 12'd0 : w_bytes - 12'd4;
  assign w_len      = (w_len_full > 12'd2047) ? 11'h7FF : w_len_full[10:0];
  assign w_ok       = (w_crc == CRC_RESIDUE) && (r_cnt[1:0] == 2'b00)
                      && (w_bytes >= c_min_bytes) && (w_bytes <= c_max_bytes);

  // The oldest entry leaves only once 16 dibits are held, so the trailing
  // FCS is still in the line at end of carrier and is simply abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_v <= 1'b0;
      r_pop_d <= 2'b00;
      r_axiov <= 1'b0;
      r_axiod <= 2'b00;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
      r_len   <= 11'd0;
    end else begin
      r_pop_v <= w_shift && (r_cnt >= 14'd16);
      r_pop_d <= r_line[15];
      r_axiov <= r_pop_v;
      r_axiod <= r_pop_v ? r_pop_d : 2'b00;
      r_done  <= w_done;
      r_ok    <= w_done & w_ok;
      r_len   <= w_done ? w_len : 11'd0;
    end
  end

  assign rx.axiov      = r_axiov;
  assign rx.axiod      = r_axiod;
  assign rx.frame_done = r_done;
  assign rx.frame_ok   = r_ok;
  assign rx.frame_len  = r_len;

endmodule
`default_nettype wire
